led7seg_scan_drv: RTL
=====================

LED7SEG_SCAN_DRV -- requirements
Module: led7seg_scan_drv

Interface
REQ-001 SHALL have parameter C_FCK, default 48_000_000, meaning the CK_i frequency in Hz.
REQ-002 SHALL have parameter C_FSCAN, default 10_000, meaning the digit-step rate in Hz.
REQ-003 SHALL have parameter C_DIGITS, default 4, legal 1..8, meaning the number of multiplexed digits.
REQ-004 SHALL have parameter C_BLANK_CYC, default 16, legal 1..(C_FCK/C_FSCAN)/2, meaning the anti-ghost blank length in CK_i cycles.
REQ-005 SHALL have port CK_i, input, 1 bit, system clock, all logic on its rising edge.
REQ-006 SHALL have port XARST_i, input, 1 bit, reset, asynchronous, active-low.
REQ-007 SHALL have port DAT_i, input, 4*C_DIGITS bits, hex nibbles; the top nibble is the leftmost digit.
REQ-008 SHALL have port DP_i, input, C_DIGITS bits, per-digit decimal point.
REQ-009 SHALL have port LATCH_i, input, 1 bit, capture-enable for DAT_i, DP_i and SUP_EN_i.
REQ-010 SHALL have port SUP_EN_i, input, 1 bit, leading-zero suppression enable.
REQ-011 SHALL have port BRIGHT_i, input, 4 bits, brightness, where 0 = off and 15 = full; present only with LED7SEG_BRIGHT_EN.
REQ-012 SHALL have port ACT_DIGIT_o, output, C_DIGITS bits, one-hot digit anode, active-high.
REQ-013 SHALL have port SEG7_o, output, 7 bits, segments gfedcba, active-high.
REQ-014 SHALL have port DP_o, output, 1 bit, decimal-point segment, active-high.

Function
REQ-015 SHALL generate a one-cycle TICK every C_FCK/C_FSCAN cycles using a free-running divider.
REQ-016 SHALL update the shadow registers DAT_D, DP_D and SUP_D on the cycle after LATCH_i=1; no other event updates them.
REQ-017 SHALL run a 2-state FSM:
- SHOW to BLANK on TICK.
- BLANK to SHOW after exactly C_BLANK_CYC cycles.
REQ-018 SHALL, while in BLANK, drive ACT_DIGIT_o=0, SEG7_o=0 and DP_o=0.
REQ-019 SHALL advance the digit index by one on entry to BLANK, in the order MSB digit to LSB digit, then wrap to the MSB digit.
REQ-020 SHALL, on the first SHOW cycle, present the selected nibble decoded (0-F, the standard hex glyphs) together with its DP bit; SEG7_o and ACT_DIGIT_o SHALL change on the same cycle.
REQ-021 SHALL decide suppression as follows when SUP_D=1:
- The MSB digit is suppressed if its nibble is 0.
- Each lower digit is suppressed if it is 0 and every digit above it in the same frame was suppressed.
- The LSB digit SHALL never be suppressed.
REQ-022 SHALL, for a suppressed digit, drive SEG7_o=0 while still driving its DP bit and ACT_DIGIT_o.
REQ-023 SHALL leave the current frame's displayed values unaffected by a LATCH_i arriving mid-frame, except for digits not yet shown.
REQ-024 SHALL, with C_DIGITS=1, keep digit index 0 permanently and still apply BLANK.
REQ-025 SHALL, when TICK and an FSM transition coincide, give BLANK entry priority; the divider SHALL never stall.

Reset
REQ-026 SHALL, on XARST_i low, immediately force:
- The divider to C_FCK/C_FSCAN-1.
- The FSM to BLANK with the blank counter at 0.
- The digit index to the LSB, so the first SHOW is the MSB digit.
- DAT_D, DP_D and SUP_D to 0.
- ACT_DIGIT_o, SEG7_o and DP_o to 0.
REQ-027 SHALL resume normal operation on the first CK_i edge after XARST_i rises; a reset mid-frame SHALL discard the frame.

Configuration
REQ-028 SHALL, with LED7SEG_BRIGHT_EN defined:
- Add BRIGHT_i.
- Within SHOW, divide the remaining period into 16 equal slots and gate ACT_DIGIT_o, SEG7_o and DP_o on only during slots 0..BRIGHT_i-1.
- BRIGHT_i is sampled at BLANK exit.
REQ-029 SHALL, without LED7SEG_BRIGHT_EN, omit BRIGHT_i and hold SHOW outputs on for the whole SHOW period.

Structure
REQ-030 SHALL place the 7-segment hex glyph table function, the FSM state typedef (BLANK, SHOW) and the ceil-log2 width function in shared package led7seg_pkg.
REQ-031 SHALL contain one sub-module, led7seg_tick_gen (divider producing TICK), reusable by other display blocks.

Verification
REQ-032 SHALL verify: C_DIGITS=4, DAT_i=16'h12AF, LATCH_i pulse -> successive SHOW phases output 1 (0000110), 2 (1011011), A (1110111), F (1110001) on ACT_DIGIT_o 1000, 0100, 0010, 0001.
REQ-033 SHALL verify: SUP_EN_i=1, DAT_i=16'h0000 -> digits 3..1 SEG7_o=0; digit 0 SEG7_o=0111111; DAT_i=16'h0102 -> only digit 3 is blank.
REQ-034 SHALL verify: DP_i=4'b0010 -> DP_o=1 only while ACT_DIGIT_o=0010, including when that digit is suppressed.
REQ-035 SHALL verify: at each digit change, all outputs are 0 for exactly C_BLANK_CYC cycles.
REQ-036 SHALL verify: XARST_i asserted mid-SHOW -> outputs are 0 asynchronously; after release, the first SHOW is the MSB digit after one full scan period plus the blank.
REQ-037 SHALL verify: with LED7SEG_BRIGHT_EN, BRIGHT_i=4 -> on-time is 4/16 of SHOW ±1 cycle; BRIGHT_i=0 -> ACT_DIGIT_o never asserts.

Source files
------------

// File: rtl/led7seg_pkg.sv
// Shared types and helpers for the 7-segment display driver family.
package led7seg_pkg;

  typedef logic [0:0] led7seg_state_t;
  localparam led7seg_state_t ST_BLANK = 1'b0;
  localparam led7seg_state_t ST_SHOW  = 1'b1;

  function automatic int unsigned f_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Segment order gfedcba, active-high.
  function automatic logic [6:0] f_seg7_hex(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/led7seg_tick_gen.sv
// Free-running down-counter producing a one-cycle tick every C_DIV clocks.
// Reset loads the full period so the first tick comes one period after release.
module led7seg_tick_gen
  import led7seg_pkg::*;
#(
  parameter int unsigned C_DIV = 4800
) (
  input  logic i_ck,
  input  logic i_xarst,
  output logic o_tick
);
  localparam int unsigned CNT_W = f_clog2(C_DIV);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(C_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_ck or negedge i_xarst) begin
    if (!i_xarst)             r_cnt <= CNT_TOP;
    else if (r_cnt == '0)     r_cnt <= CNT_TOP;
    else                      r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/led7seg_scan_drv.sv
// Multiplexed 7-segment scan driver with anti-ghost blanking and leading-zero
// suppression. Define LED7SEG_BRIGHT_EN to add BRIGHT_i PWM dimming.
module led7seg_scan_drv
  import led7seg_pkg::*;
#(
  parameter int unsigned C_FCK       = 48_000_000,
  parameter int unsigned C_FSCAN     = 10_000,
  parameter int unsigned C_DIGITS    = 4,
  parameter int unsigned C_BLANK_CYC = 16
) (
  input  logic                  CK_i,
  input  logic                  XARST_i,
  input  logic [4*C_DIGITS-1:0] DAT_i,
  input  logic [C_DIGITS-1:0]   DP_i,
  input  logic                  LATCH_i,
  input  logic                  SUP_EN_i,
`ifdef LED7SEG_BRIGHT_EN
  input  logic [3:0]            BRIGHT_i,
`endif
  output logic [C_DIGITS-1:0]   ACT_DIGIT_o,
  output logic [6:0]            SEG7_o,
  output logic                  DP_o
);
  localparam int unsigned C_DIV = C_FCK / C_FSCAN;
  localparam int unsigned IDX_W = f_clog2(C_DIGITS);
  localparam int unsigned BLK_W = f_clog2(C_BLANK_CYC + 1);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(C_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_END = BLK_W'(C_BLANK_CYC);

  logic                  w_tick;
  logic                  w_exit;
  logic                  w_on;
  logic                  w_sup;
  logic [3:0]            w_nib;
  logic                  w_dp_bit;
  logic [C_DIGITS-1:0]   w_onehot;

  logic [4*C_DIGITS-1:0] r_dat;
  logic [C_DIGITS-1:0]   r_dp;
  logic                  r_sup;
  led7seg_state_t        r_state;
  logic [BLK_W-1:0]      r_blk;
  logic [IDX_W-1:0]      r_idx;
  logic [C_DIGITS-1:0]   r_act;
  logic [6:0]            r_seg;
  logic                  r_dpo;
  logic                  r_sup_run;

  led7seg_tick_gen #(.C_DIV(C_DIV)) u_tick (
    .i_ck    (CK_i),
    .i_xarst (XARST_i),
    .o_tick  (w_tick)
  );

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_dat <= '0;
      r_dp  <= '0;
      r_sup <= 1'b0;
    end else if (LATCH_i) begin
      r_dat <= DAT_i;
      r_dp  <= DP_i;
      r_sup <= SUP_EN_i;
    end
  end

  always_comb begin
    w_nib    = '0;
    w_dp_bit = 1'b0;
    w_onehot = '0;
    for (int unsigned i = 0; i < C_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_dat[4*i +: 4];
        w_dp_bit    = r_dp[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // r_sup_run remembers whether every digit shown so far in this frame was blanked.
  assign w_sup  = r_sup && (w_nib == 4'h0) && (r_idx != '0) &&
                  ((r_idx == IDX_MSB) || r_sup_run);
  // r_blk == 0 only after reset: hold blank until the first tick so the scan starts at the MSB.
  assign w_exit = (r_state == ST_BLANK) && (r_blk == BLK_END) && !w_tick;

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_state   <= ST_BLANK;
      r_blk     <= '0;
      r_idx     <= '0;
      r_act     <= '0;
      r_seg     <= '0;
      r_dpo     <= 1'b0;
      r_sup_run <= 1'b0;
    end else if (w_tick) begin
      r_state <= ST_BLANK;
      r_blk   <= BLK_W'(1);
      r_idx   <= (r_idx == '0) ? IDX_MSB : r_idx - IDX_W'(1);
    end else if (w_exit) begin
      r_state   <= ST_SHOW;
      r_blk     <= '0;
      r_act     <= w_onehot;
      r_seg     <= w_sup ? '0 : f_seg7_hex(w_nib);
      r_dpo     <= w_dp_bit;
      r_sup_run <= w_sup;
    end else if ((r_state == ST_BLANK) && (r_blk != '0)) begin
      r_blk <= r_blk + BLK_W'(1);
    end
  end

`ifdef LED7SEG_BRIGHT_EN
  localparam int unsigned SLOT_RAW = (C_DIV - C_BLANK_CYC) / 16;
  localparam int unsigned SLOT     = (SLOT_RAW == 0) ? 1 : SLOT_RAW;
  localparam int unsigned SC_W     = f_clog2(C_DIV + 1);
  localparam int unsigned LIM_W    = SC_W + 5;

  logic [SC_W-1:0]  r_scnt;
  logic [3:0]       r_brt;
  logic [LIM_W-1:0] w_lim;

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_scnt <= '0;
      r_brt  <= '0;
    end else if (w_exit) begin
      r_scnt <= '0;
      r_brt  <= BRIGHT_i;
    end else if ((r_state == ST_SHOW) && !w_tick) begin
      r_scnt <= r_scnt + SC_W'(1);
    end
  end

  assign w_lim = LIM_W'(r_brt) * LIM_W'(SLOT);
  assign w_on  = (r_state == ST_SHOW) && (LIM_W'(r_scnt) < w_lim);
`else
  assign w_on  = (r_state == ST_SHOW);
`endif

  assign ACT_DIGIT_o = w_on ? r_act : '0;
  assign SEG7_o      = w_on ? r_seg : '0;
  assign DP_o        = w_on & r_dpo;

endmodule
